seg7_scan_reader: RTL

//   Receive side of the multiplexed 7-segment display interface: watches an active-low

---
 rtl/seg7_scan_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed 7-segment display bus. Samples the active-low
// anode/segment buses, waits for a stable pattern, decodes it to BCD per digit,
// flags illegal segment patterns and reports when a full frame has been seen.
module seg7_scan_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  capture,
  output logic                  frame_valid
);

  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

  logic [SW-1:0]             s_q, s_prev_q;
  logic [CW-1:0]             count_q, count_d;
  logic [DIGITS-1:0]         seen_q, seen_d;
  logic                      capture_q, capture_d;
  logic                      frame_q, frame_d;
  logic [DIGITS-1:0][3:0]    code_q;
  logic [DIGITS-1:0]         err_q;

  logic [3:0]                n_low;
  logic                      active;
  logic [DIGITS-1:0]         sel;
  logic [DIGITS-1:0]         seen_or;
  logic [3:0]                dec_code;
  logic                      dec_err;

  // Input stage: one register for the sampled bus, one for its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '1;
      s_prev_q <= '1;
    end else begin
      s_q      <= {an, seg};
      s_prev_q <= s_q;
    end
  end

  // Classify the anodes, run the stability counter and detect the capture point.
  always_comb begin
    n_low = '0;
    for (int k = 0; k < DIGITS; k++) n_low = n_low + {3'b000, ~s_q[7+k]};
    active = (n_low == 4'd1);
    if (!active)               count_d = '0;
    else if (s_q == s_prev_q)  count_d = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
    else                       count_d = CW'(1);
    // Only the step into the maximum captures; holding at max does not re-fire.
    capture_d = (count_d == CNT_MAX) && (count_q != CNT_MAX);
    sel       = capture_d ? ~s_q[SW-1:7] : '0;
  end

  // Segment decode of the sampled pattern (active-low, bit0 = a).
  always_comb begin
    dec_err  = 1'b0;
    dec_code = 4'hE;
    case (s_q[6:0])
      7'b1000000: dec_code = 4'h0;
      7'b1111001: dec_code = 4'h1;
      7'b0100100: dec_code = 4'h2;
      7'b0110000: dec_code = 4'h3;
      7'b0011001: dec_code = 4'h4;
      7'b0010010: dec_code = 4'h5;
      7'b0000010: dec_code = 4'h6;
      7'b1111000: dec_code = 4'h7;
      7'b0000000: dec_code = 4'h8;
      7'b0010000: dec_code = 4'h9;
      7'b1111111: dec_code = 4'hF;
      default:    dec_err  = 1'b1;
    endcase
  end

  // Frame tracking: the capture that completes the seen mask pulses and clears it.
  always_comb begin
    seen_or = seen_q | sel;
    frame_d = 1'b0;
    seen_d  = seen_q;
    if (capture_d) begin
      if (&seen_or) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_or;
      end
    end
  end

  // Control state: counter, seen mask and the two output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      seen_q    <= '0;
      capture_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      seen_q    <= seen_d;
      capture_q <= capture_d;
      frame_q   <= frame_d;
    end
  end

  // Per-digit code/error registers, written only when that digit is captured.
  for (genvar k = 0; k < DIGITS; k++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        code_q[k] <= 4'hF;
        err_q[k]  <= 1'b0;
      end else if (sel[k]) begin
        code_q[k] <= dec_code;
        err_q[k]  <= dec_err;
      end
    end
  end

  assign digits      = code_q;
  assign digit_err   = err_q;
  assign capture     = capture_q;
  assign frame_valid = frame_q;

endmodule
